// File: rtl/pair_gen_pkg.sv
// Shared definitions for the pair-count serializer (transmit) and its receive-side peer.
//   WORD_W     : bits per serialized word
//   PAIR_CNT_W : width of the 1->0 pair count (must hold WORD_W/2)
//   pg_state_e : transmit FSM states
package pair_gen_pkg;

  localparam int unsigned WORD_W     = 8;
  localparam int unsigned PAIR_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } pg_state_e;

endpackage

// File: rtl/pair_gen_tx_piso_shifter.sv
// Parallel-in serial-out shift register; shifts right, serial bit is bit 0.
//   clk, rst  : clock, async active-low reset
//   load_en   : load load_data (has priority over shift_en)
//   shift_en  : shift right by one, zero fill at the MSB
//   load_data : parallel word
//   ser       : current serial bit (shreg[0])
module piso_shifter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_en,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] load_data,
  output logic             ser
);

  logic [WIDTH-1:0] shreg;

  // Load wins over shift so a new word never picks up a stale shift.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg <= '0;
    end else if (load_en) begin
      shreg <= load_data;
    end else if (shift_en) begin
      shreg <= {1'b0, shreg[WIDTH-1:1]};
    end
  end

  assign ser = shreg[0];

endmodule

// File: rtl/pair_gen_tx.sv
// Serializes a word LSB-first over a bit-level valid/ready link and counts the
// 1->0 bit pairs sent within the word, reporting the count when the word completes.
//   clk, rst            : clock, async active-low reset
//   in_valid/in_ready   : word handshake, in_data is the word
//   ser_out/ser_valid   : serial bit and its valid
//   ser_ready           : sink accepts the current bit
//   ser_last            : current bit is the word's MSB
//   done                : one-cycle pulse after the last bit is accepted
//   pair_count          : 1->0 pair count of the last completed word
module pair_gen_tx
  import pair_gen_pkg::*;
#(
  parameter int unsigned WIDTH = WORD_W,
  parameter int unsigned CNT_W = PAIR_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_last,
  output logic             done,
  output logic [CNT_W-1:0] pair_count
);

  localparam int unsigned IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  pg_state_e        state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] pair_count_d;
  logic             prev_q, prev_d;
  logic             load_en, shift_en;
  logic             pair_inc;
  logic             ser_bit;

  piso_shifter #(
    .WIDTH (WIDTH)
  ) u_shifter (
    .clk       (clk),
    .rst       (rst),
    .load_en   (load_en),
    .shift_en  (shift_en),
    .load_data (in_data),
    .ser       (ser_bit)
  );

  assign ser_out = ser_bit;

  // A pair ends on the bit being sent now; bit 0 never closes a pair.
  assign pair_inc = (idx_q != '0) && prev_q && !ser_bit;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      prev_q     <= 1'b0;
      pair_count <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      prev_q     <= prev_d;
      pair_count <= pair_count_d;
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    prev_d       = prev_q;
    pair_count_d = pair_count;
    load_en      = 1'b0;
    shift_en     = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          load_en = 1'b1;
          idx_d   = '0;
          cnt_d   = '0;
          prev_d  = 1'b0;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        if (ser_ready) begin
          shift_en = 1'b1;
          prev_d   = ser_bit;
          cnt_d    = cnt_q + CNT_W'(pair_inc);
          if (idx_q == LAST_IDX) begin
            pair_count_d = cnt_q + CNT_W'(pair_inc);
            idx_d        = '0;
            state_d      = DONE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Handshake/status outputs registered from the next state so they never
  // depend combinationally on ser_ready or in_valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_ready  <= 1'b1;
      ser_valid <= 1'b0;
      ser_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      in_ready  <= (state_d == IDLE);
      ser_valid <= (state_d == SHIFT);
      ser_last  <= (state_d == SHIFT) && (idx_d == LAST_IDX);
      done      <= (state_d == DONE);
    end
  end

endmodule

// File: tb/tb_pair_gen_tx.sv
// Self-checking bench for pair_gen_tx: table of known words, stall, back-to-back,
// async reset mid-word, and random words with random sink back-pressure.
module tb_pair_gen_tx;

  localparam int unsigned W = 8;
  localparam int unsigned C = 4;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         ser_out;
  logic         ser_valid;
  logic         ser_ready;
  logic         ser_last;
  logic         done;
  logic [C-1:0] pair_count;

  int n_checks;
  int n_fail;
  int cyc;
  int last_exp;
  int accept_cyc;
  int done_cyc;

  pair_gen_tx #(
    .WIDTH (W),
    .CNT_W (C)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .ser_out    (ser_out),
    .ser_valid  (ser_valid),
    .ser_ready  (ser_ready),
    .ser_last   (ser_last),
    .done       (done),
    .pair_count (pair_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] data;
    int           exp_pairs;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: count positions k>=1 where bit k-1 is 1 and bit k is 0.
  function automatic int model_pairs(input logic [W-1:0] d);
    int n;
    n = 0;
    for (int k = 1; k < W; k++) begin
      if (d[k-1] && !d[k]) n++;
    end
    return n;
  endfunction

  // Send one word starting at a negedge in IDLE; returns at the negedge of
  // the IDLE cycle following done.
  task automatic send_word(input logic [W-1:0] d, input int exp, input bit rnd,
                           input int stall_idx, input int stall_n,
                           input bit keep, input logic [W-1:0] nxt);
    int  i;
    int  budget;
    int  stalled;
    bit  rdy;
    check("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk);
    @(negedge clk);
    accept_cyc = cyc;
    in_valid   = keep;
    if (keep) in_data = nxt;
    check("pair_count_hold", 32'(pair_count), 32'(last_exp));
    i       = 0;
    budget  = 0;
    stalled = 0;
    while (i < W && budget < 200) begin
      check("ser_valid", 32'(ser_valid), 32'd1);
      check("ser_out", 32'(ser_out), 32'(d[i]));
      check("ser_last", 32'(ser_last), 32'(i == W - 1));
      check("in_ready_busy", 32'(in_ready), 32'd0);
      check("done_early", 32'(done), 32'd0);
      if (rnd) rdy = ($urandom_range(0, 3) != 0);
      else if (i == stall_idx && stalled < stall_n) begin
        rdy = 1'b0;
        stalled++;
      end else rdy = 1'b1;
      ser_ready = rdy;
      @(posedge clk);
      if (rdy) i++;
      budget++;
      @(negedge clk);
    end
    if (budget >= 200) begin
      n_checks++;
      n_fail++;
      $display("FAIL word_timeout: bits sent %0d, expected %0d", i, W);
    end
    ser_ready = 1'b1;
    done_cyc = cyc;
    check("done_pulse", 32'(done), 32'd1);
    check("done_ser_valid", 32'(ser_valid), 32'd0);
    check("done_in_ready", 32'(in_ready), 32'd0);
    check("pair_count", 32'(pair_count), 32'(exp));
    @(posedge clk);
    @(negedge clk);
    check("done_cleared", 32'(done), 32'd0);
    check("in_ready_back", 32'(in_ready), 32'd1);
    check("idle_ser_valid", 32'(ser_valid), 32'd0);
    last_exp = exp;
  endtask

  vec_t vecs[8];
  int   prev_accept;
  logic [W-1:0] rd;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    last_exp = 0;
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    ser_ready = 1'b1;

    vecs[0] = '{8'h55, 4};
    vecs[1] = '{8'hAA, 3};
    vecs[2] = '{8'h0F, 1};
    vecs[3] = '{8'h00, 0};
    vecs[4] = '{8'hFF, 0};
    vecs[5] = '{8'h01, 1};
    vecs[6] = '{8'h80, 0};
    vecs[7] = '{8'h3C, 1};

    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_ser_valid", 32'(ser_valid), 32'd0);
    check("rst_ser_last", 32'(ser_last), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ser_out", 32'(ser_out), 32'd0);
    check("rst_pair_count", 32'(pair_count), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Known words with the sink always ready; checks exact T+1..T+9 timing.
    foreach (vecs[v]) begin
      send_word(vecs[v].data, vecs[v].exp_pairs, 1'b0, -1, 0, 1'b0, '0);
      check("latency_done", 32'(done_cyc - accept_cyc), 32'(W));
    end

    // Sink stalls 3 cycles while bit 4 of 0x55 is presented.
    send_word(8'h55, 4, 1'b0, 4, 3, 1'b0, '0);
    check("stall_latency", 32'(done_cyc - accept_cyc), 32'(W + 3));

    // Back-to-back with in_valid held high; data changes mid-word are ignored.
    send_word(8'h55, 4, 1'b0, -1, 0, 1'b1, 8'h0F);
    prev_accept = accept_cyc;
    send_word(8'h0F, 1, 1'b0, -1, 0, 1'b0, '0);
    check("b2b_spacing", 32'(accept_cyc - prev_accept), 32'(W + 2));

    // Async reset during bit 3 of 0xAA.
    in_valid = 1'b1;
    in_data  = 8'hAA;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("pre_rst_bit3", 32'(ser_out), 32'd1);
    check("pre_rst_valid", 32'(ser_valid), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("async_ser_valid", 32'(ser_valid), 32'd0);
    check("async_in_ready", 32'(in_ready), 32'd1);
    check("async_pair_count", 32'(pair_count), 32'd0);
    repeat (2) begin
      @(negedge clk);
      check("rst_no_done", 32'(done), 32'd0);
    end
    rst = 1'b1;
    last_exp = 0;
    @(negedge clk);
    check("post_rst_no_done", 32'(done), 32'd0);
    send_word(8'h55, 4, 1'b0, -1, 0, 1'b0, '0);

    // Random words with random back-pressure against the reference model.
    for (int r = 0; r < 40; r++) begin
      rd = W'($urandom);
      send_word(rd, model_pairs(rd), 1'b1, -1, 0, 1'b0, '0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pair_gen_tx.md
Name: pair_gen_tx

Overview:
Transmit-side counterpart of the team's byte shift-and-count datapath.
- Accepts an 8-bit word over a valid/ready handshake and serializes it LSB-first over a bit-level valid/ready link.
- Counts the "1 then 0" bit pairs it transmits within the word and reports the count when the word completes, so the receive path's count is checked end to end.

Parameters:
WIDTH, 8, bits per word; even, >= 2.
CNT_W, 4, width of pair_count; must hold WIDTH/2.

Ports:
clk  input  1  system clock; rising edge.
rst  input  1  reset, asynchronous, active-low.
in_valid  input  1  in_data is valid.
in_data  input  WIDTH  word to transmit.
in_ready  output  1  block can accept a word this cycle.
ser_out  output  1  current serial bit.
ser_valid  output  1  ser_out is valid.
ser_ready  input  1  sink accepts ser_out this cycle.
ser_last  output  1  current bit is bit WIDTH-1 of the word.
done  output  1  one-cycle pulse after the last bit is accepted.
pair_count  output  CNT_W  count of 1->0 pairs in the last completed word.

Behaviour:
Reset
- rst low: state IDLE immediately, asynchronously.
- Shift register, bit index, prev_bit and pair_count all 0.
- ser_valid=0, ser_last=0, done=0, ser_out=0, in_ready=1.
- Reset mid-word aborts the word: no done pulse, partial count discarded.

FSM states: IDLE, SHIFT, DONE.
- IDLE: in_ready=1, ser_valid=0.
  - in_valid=1: load in_data into the shift register, index=0, clear the running count, go to SHIFT.
  - pair_count keeps the previous word's value until this load.
- SHIFT: in_ready=0, ser_valid=1, ser_out = shreg[0], ser_last = (index==WIDTH-1).
  - ser_ready=0: hold all state; ser_out, ser_valid and ser_last stay stable.
  - ser_ready=1: if index>0 and prev_bit==1 and ser_out==0, increment the running count. Then prev_bit=ser_out, shift right, index+1.
  - ser_ready=1 with ser_last=1: copy the final running count (including this bit) to pair_count, go to DONE.
- DONE: done=1 for exactly one cycle, in_ready=0, ser_valid=0, then go to IDLE.

Pair rules
- Pairs never span words; prev_bit is ignored at index 0.
- Count does not saturate; maximum is WIDTH/2.

Timing (word accepted at edge T, ser_ready held high)
- Bit 0 on ser_out in cycle T+1.
- Last bit in cycle T+WIDTH.
- done in cycle T+WIDTH+1.
- in_ready high again in cycle T+WIDTH+2.
- Throughput: one word per WIDTH+2 cycles.

Other rules
- in_valid is ignored outside IDLE; the source must hold the word until in_ready.
- All outputs are registered or decoded from state only; no combinational path from ser_ready to ser_valid.

Decomposition:
Shared package:
- typedef enum of the FSM states {IDLE, SHIFT, DONE}.
- Constants WORD_W=8 and PAIR_CNT_W=4, also used by the receive path.
Sub-module piso_shifter:
- Parallel-load, shift-right register with load_en and shift_en; serial out is bit 0.
- Mirrors the receive-side shifter.
FSM, index counter and pair counter stay in the top.

Test Plan:
- in_data=0x55, ser_ready=1 -> ser_out 1,0,1,0,1,0,1,0 in cycles T+1..T+8; ser_last only at T+8; done at T+9; pair_count=4.
- in_data=0xAA -> bits 0,1,0,1,0,1,0,1; pair_count=3.
- in_data=0x0F -> pair_count=1.
- in_data=0x00 -> pair_count=0.
- in_data=0xFF -> pair_count=0.
- 0x55 with ser_ready low for 3 cycles at bit 4 -> ser_out=1 and ser_valid=1 held stable; done delayed 3 cycles; pair_count=4.
- Back-to-back words 0x55 then 0x0F with in_valid held high -> second word accepted at T+10; pair_count goes 4 then 1; in_valid is ignored during SHIFT/DONE.
- rst pulsed low during bit 3 of 0xAA -> ser_valid=0 and state IDLE with no clock edge; no done; pair_count=0; next word 0x55 gives pair_count=4.
